// File: rtl/sine_rom_arbiter.sv
// sine_rom_arbiter: round-robin arbiter that shares one registered sine ROM
// among N_REQ requesters. It issues one ROM read per cycle and returns the
// data one cycle later with a one-hot strobe naming the owning requester.
// Optional feature macro: SINE_ARB_QUARTER_WAVE_EN. When it is defined, the
// ROM holds a quarter wave, and the two upper phase bits select mirroring
// and sign.
module sine_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
`ifdef SINE_ARB_QUARTER_WAVE_EN
  localparam int PH_W  = ADDR_W + 2
`else
  localparam int PH_W  = ADDR_W
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*PH_W-1:0]   req_addr_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    rom_cen_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DATA_W-1:0]       rom_data_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PH_W-1:0]   phase [N_REQ];
  logic [PTR_W-1:0]  ptr_q;
  logic [N_REQ-1:0]  owner_q;
  logic [DATA_W-1:0] hold_q;

  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    cand;
  logic              grant_valid;
  logic [N_REQ-1:0]  grant_onehot;
  logic [PH_W-1:0]   sel_phase;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] rsp_data_now;

  // Unpack the per-requester phases and build the one-hot grant vector.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign phase[gi]        = req_addr_i[gi*PH_W +: PH_W];
      assign grant_onehot[gi] = grant_valid && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  // Scan requesters starting at ptr_q and wrapping; the first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      if (!grant_found && req_valid_i[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Reset forces the handshake and the ROM enable low.
  assign grant_valid = grant_found && !rst_i;
  assign sel_phase   = phase[grant_idx];

`ifdef SINE_ARB_QUARTER_WAVE_EN
  logic sign_q;

  // In the second and fourth quadrants the phase is mirrored onto the quarter wave.
  always_comb begin
    sel_addr = sel_phase[PH_W-2] ? ~sel_phase[ADDR_W-1:0] : sel_phase[ADDR_W-1:0];
  end

  // The magnitude is offset around mid-scale, and the registered sign chooses the half.
  always_comb begin
    if (sign_q) begin
      rsp_data_now = {1'b1, {(DATA_W-1){1'b0}}} - {1'b0, rom_data_i[DATA_W-2:0]};
    end else begin
      rsp_data_now = {1'b1, {(DATA_W-1){1'b0}}} + {1'b0, rom_data_i[DATA_W-2:0]};
    end
  end

  // The sign travels alongside the read so that it lines up with the ROM data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sign_q <= 1'b0;
    end else if (grant_valid) begin
      sign_q <= sel_phase[PH_W-1];
    end
  end
`else
  // In the full-wave build, the phase is the ROM address and the data passes through unchanged.
  always_comb begin
    sel_addr     = sel_phase[ADDR_W-1:0];
    rsp_data_now = rom_data_i;
  end
`endif

  assign req_ready_o = grant_onehot;
  assign rom_cen_o   = grant_valid;
  assign rom_addr_o  = grant_valid ? sel_addr : '0;

  // A read in flight when reset is asserted is suppressed at the output.
  assign rsp_valid_o = owner_q & {N_REQ{~rst_i}};
  assign rsp_data_o  = (|rsp_valid_o) ? rsp_data_now : hold_q;

  // Advance the pointer and track the read owner. Keep a copy of the last response for idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      owner_q <= grant_onehot;
      if (grant_valid) begin
        ptr_q <= (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      if (|owner_q) begin
        hold_q <= rsp_data_now;
      end
    end
  end

endmodule
